lane_ctrl: RTL and testbench

LANE_CTRL -- requirements
Module: lane_ctrl

---
 rtl/vect_pkg.sv | 28 ++
 rtl/lane_ctrl_if.sv | 13 +
 rtl/lane_instr_fifo.sv | 48 ++++
 rtl/lane_ctrl.sv | 155 +++++++++++++++
 tb/tb_lane_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vect_pkg.sv
// Shared types for the vector lane controller: instruction word, FSM state
// and the effective-length helper.
package vect_pkg;

  localparam int VL_W = 8;

  typedef struct packed {
    logic [4:0]      vd;
    logic [4:0]      vs1;
    logic [4:0]      vs2;
    logic [VL_W-1:0] vl;
    logic            vm;
    logic            use_c;
  } lane_instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } lane_state_t;

  // Element count actually issued: vl clipped to the lane's register length.
  function automatic logic [VL_W-1:0] eff_vl(input logic [VL_W-1:0] vl,
                                             input int unsigned elems);
    return (vl > VL_W'(elems)) ? VL_W'(elems) : vl;
  endfunction

endpackage

// File: rtl/lane_ctrl_if.sv
// Instruction handshake bundle: a transfer happens on a clock edge where
// instr_valid and instr_ready are both high; instr must hold while valid waits.
interface lane_ctrl_if;
  import vect_pkg::*;

  logic        instr_valid;
  lane_instr_t instr;
  logic        instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/lane_instr_fifo.sv
// Instruction queue for the lane controller; pointers wrap modulo QDEPTH
// (a power of two), occupancy counter drives full/empty.
module lane_instr_fifo
  import vect_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  lane_instr_t data_i,
  input  logic        pop_i,
  output lane_instr_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = $clog2(QDEPTH);

  lane_instr_t  mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push_s, pop_s;

  assign full_o  = (count_q == (PW+1)'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_s && !pop_s)      count_q <= count_q + 1'b1;
      else if (pop_s && !push_s) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/lane_ctrl.sv
// Vector lane controller: queues instructions, issues one element per cycle
// through a read/execute/writeback pipe. Macro LANE_CTRL_MASK_EN enables masking.
module lane_ctrl
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMS      = 4,
  parameter int RD_LAT     = 2,
  parameter int EXE_LAT    = 3,
  parameter int QDEPTH     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_valid_i,
  input  lane_instr_t              instr_i,
  output logic                     instr_ready_o,
  input  logic [ELEMS-1:0]         mask_bits_i,
  input  logic                     stall_i,
  output logic                     rd_en_o,
  output logic [$clog2(ELEMS)-1:0] rd_elem_o,
  output logic [4:0]               rd_vs1_o,
  output logic [4:0]               rd_vs2_o,
  output logic [4:0]               rd_vs3_o,
  output logic                     exe_valid_o,
  output logic                     wb_en_o,
  output logic [$clog2(ELEMS)-1:0] wb_elem_o,
  output logic [4:0]               wb_vd_o,
  output logic                     busy_o,
  output logic                     done_o,
  output lane_state_t              dbg_state_o
);

  localparam int EW    = $clog2(ELEMS);
  localparam int DEPTH = RD_LAT + EXE_LAT;
  localparam int unused_data_width = DATA_WIDTH;

  lane_state_t     state_q, state_d;
  lane_instr_t     cur_q, cur_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic [DEPTH-1:0] pipe_v_q;
  logic [EW-1:0]   pipe_idx_q [DEPTH];

  lane_instr_t     fifo_data;
  logic            fifo_full, fifo_empty, pop_s, done_s;
  logic            issue_s, last_elem, upper_empty, wb_ok;
  logic [VL_W-1:0] vl_eff;

  lane_instr_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (instr_valid_i),
    .data_i  (instr_i),
    .pop_i   (pop_s),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign vl_eff      = eff_vl(cur_q.vl, ELEMS);
  assign issue_s     = (state_q == ST_ISSUE) && !stall_i && (vl_eff != '0);
  assign last_elem   = (VL_W'(elem_q) == vl_eff - 1'b1);
  assign upper_empty = ~|pipe_v_q[DEPTH-2:0];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    elem_d  = elem_q;
    pop_s   = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_s   = 1'b1;
          cur_d   = fifo_data;
          elem_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall_i) begin
          if (vl_eff == '0) begin
            state_d = ST_DRAIN;
          end else if (last_elem) begin
            elem_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Elements enter back to back, so once only the writeback slot is
        // occupied (or nothing was issued) this cycle finishes the instruction.
        if (!stall_i && upper_empty) begin
          done_s = 1'b1;
          if (!fifo_empty) begin
            pop_s   = 1'b1;
            cur_d   = fifo_data;
            elem_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      elem_q  <= elem_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v_q <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_idx_q[i] <= '0;
    end else if (!stall_i) begin
      pipe_v_q      <= {pipe_v_q[DEPTH-2:0], issue_s};
      pipe_idx_q[0] <= elem_q;
      for (int i = 1; i < DEPTH; i++) pipe_idx_q[i] <= pipe_idx_q[i-1];
    end
  end

`ifdef LANE_CTRL_MASK_EN
  assign wb_ok = cur_q.vm | mask_bits_i[pipe_idx_q[DEPTH-1]];
`else
  logic unused_mask;
  assign unused_mask = ^{mask_bits_i, cur_q.vm};
  assign wb_ok       = 1'b1;
`endif

  assign instr_ready_o = !fifo_full;
  assign rd_en_o       = issue_s;
  assign rd_elem_o     = elem_q;
  assign rd_vs1_o      = cur_q.vs1;
  assign rd_vs2_o      = cur_q.use_c ? cur_q.vd  : cur_q.vs2;
  assign rd_vs3_o      = cur_q.use_c ? cur_q.vs2 : cur_q.vd;
  assign exe_valid_o   = pipe_v_q[RD_LAT-1] && !stall_i;
  assign wb_en_o       = pipe_v_q[DEPTH-1] && !stall_i && wb_ok;
  assign wb_elem_o     = pipe_idx_q[DEPTH-1];
  assign wb_vd_o       = cur_q.vd;
  assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
  assign done_o        = done_s;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lane_ctrl.sv
// Directed bench for lane_ctrl: per-cycle output bitmaps and element order
// compared against hand-derived expectations.
module tb_lane_ctrl;
  import vect_pkg::*;

  localparam int ELEMS = 4;
  localparam int EW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_ctrl_if lif ();

  logic [ELEMS-1:0] mask_bits;
  logic             stall;
  logic             rd_en, exe_valid, wb_en, busy, done;
  logic [EW-1:0]    rd_elem, wb_elem;
  logic [4:0]       rd_vs1, rd_vs2, rd_vs3, wb_vd;
  lane_state_t      dbg_state;

  lane_ctrl #(.DATA_WIDTH(32), .ELEMS(ELEMS), .RD_LAT(2), .EXE_LAT(3), .QDEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (lif.instr_valid),
    .instr_i       (lif.instr),
    .instr_ready_o (lif.instr_ready),
    .mask_bits_i   (mask_bits),
    .stall_i       (stall),
    .rd_en_o       (rd_en),
    .rd_elem_o     (rd_elem),
    .rd_vs1_o      (rd_vs1),
    .rd_vs2_o      (rd_vs2),
    .rd_vs3_o      (rd_vs3),
    .exe_valid_o   (exe_valid),
    .wb_en_o       (wb_en),
    .wb_elem_o     (wb_elem),
    .wb_vd_o       (wb_vd),
    .busy_o        (busy),
    .done_o        (done),
    .dbg_state_o   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd_map, exe_map, wb_map, done_map, busy_map, ready_map;
  logic [63:0] rd_seq, wb_seq;
  logic [14:0] addr_cap;
  logic [4:0]  vd_cap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic lane_instr_t mk(input int vd, input int vs1, input int vs2,
                                     input int vl, input bit vm, input bit use_c);
    lane_instr_t t;
    t.vd    = 5'(vd);
    t.vs1   = 5'(vs1);
    t.vs2   = 5'(vs2);
    t.vl    = VL_W'(vl);
    t.vm    = vm;
    t.use_c = use_c;
    return t;
  endfunction

  task automatic reset_dut();
    #1;
    rst = 1'b1;
    stall = 1'b0;
    lif.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
  endtask

  // acc_map bit k: instruction offered so it is accepted on edge k (cycle k begins).
  task automatic run_case(input int ncyc, input logic [31:0] acc_map,
                          input logic [31:0] stall_map, input logic [31:0] rst_map,
                          input lane_instr_t i0, input lane_instr_t i1,
                          input lane_instr_t i2, input logic [ELEMS-1:0] mask);
    lane_instr_t lst [3];
    int k;
    bit got_rd, got_wb;
    lst[0] = i0; lst[1] = i1; lst[2] = i2;
    k = 0; got_rd = 0; got_wb = 0;
    rd_map = '0; exe_map = '0; wb_map = '0; done_map = '0; busy_map = '0; ready_map = '0;
    rd_seq = '0; wb_seq = '0; addr_cap = '0; vd_cap = '0;
    #1;
    stall = 1'b0; rst = 1'b0; mask_bits = mask;
    lif.instr_valid = acc_map[0];
    lif.instr = lst[0];
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (lif.instr_valid && k < 2) k++;
      lif.instr_valid = acc_map[c+1];
      lif.instr = lst[k];
      stall = stall_map[c];
      rst = rst_map[c];
      #1;
      rd_map[c]    = rd_en;
      exe_map[c]   = exe_valid;
      wb_map[c]    = wb_en;
      done_map[c]  = done;
      busy_map[c]  = busy;
      ready_map[c] = lif.instr_ready;
      if (rd_en) begin
        rd_seq = (rd_seq << 4) | 64'(rd_elem);
        if (!got_rd) addr_cap = {rd_vs1, rd_vs2, rd_vs3};
        got_rd = 1;
      end
      if (wb_en) begin
        wb_seq = (wb_seq << 4) | 64'(wb_elem);
        if (!got_wb) vd_cap = wb_vd;
        got_wb = 1;
      end
      @(posedge clk);
    end
    #1;
    lif.instr_valid = 1'b0;
    stall = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    lane_instr_t nul;
    nul = mk(0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    stall = 1'b0;
    mask_bits = '1;
    lif.instr_valid = 1'b0;
    lif.instr = '0;

    reset_dut();
    #1;
    check("rst_ready", 64'(lif.instr_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", 64'({rd_en, exe_valid, wb_en, done}), 64'd0);
    check("rst_idx", 64'({rd_elem, wb_elem, wb_vd, rd_vs1, rd_vs2, rd_vs3}), 64'd0);

    // Single vl=4 instruction.
    reset_dut();
    run_case(16, 32'h1, 32'h0, 32'h0, mk(3, 1, 2, 4, 1, 0), nul, nul, 4'hF);
    check("a_rd", 64'(rd_map), 64'h1E);
    check("a_exe", 64'(exe_map), 64'h78);
    check("a_wb", 64'(wb_map), 64'h3C0);
    check("a_done", 64'(done_map), 64'h200);
    check("a_busy", 64'(busy_map), 64'h3FF);
    check("a_ready", 64'(ready_map), 64'hFFFF);
    check("a_rd_order", rd_seq, 64'h0123);
    check("a_wb_order", wb_seq, 64'h0123);
    check("a_addr", 64'(addr_cap), 64'({5'd1, 5'd2, 5'd3}));
    check("a_vd", 64'(vd_cap), 64'd3);

    // Three queued instructions: accepts on edges 0, 2, 3.
    reset_dut();
    run_case(30, 32'hD, 32'h0, 32'h0, mk(3, 1, 2, 4, 1, 0), mk(9, 1, 2, 4, 1, 0),
             mk(10, 1, 2, 2, 1, 0), 4'hF);
    check("b_rd", 64'(rd_map), 64'h183C1E);
    check("b_exe", 64'(exe_map), 64'h60F078);
    check("b_wb", 64'(wb_map), 64'h30783C0);
    check("b_done", 64'(done_map), 64'h2040200);
    check("b_ready", 64'(ready_map), 64'h3FFFFC07);
    check("b_busy", 64'(busy_map), 64'h3FFFFFF);
    check("b_wb_order", wb_seq, 64'h0123012301);

    // Stall on cycles 3-4, with vs2/vs3 swap.
    reset_dut();
    run_case(16, 32'h1, 32'h18, 32'h0, mk(7, 5, 6, 4, 1, 1), nul, nul, 4'hF);
    check("c_rd", 64'(rd_map), 64'h66);
    check("c_exe", 64'(exe_map), 64'h1E0);
    check("c_wb", 64'(wb_map), 64'hF00);
    check("c_done", 64'(done_map), 64'h800);
    check("c_busy", 64'(busy_map), 64'hFFF);
    check("c_wb_order", wb_seq, 64'h0123);
    check("c_addr", 64'(addr_cap), 64'({5'd5, 5'd7, 5'd6}));

    // vl = 0.
    reset_dut();
    run_case(16, 32'h1, 32'h0, 32'h0, mk(3, 1, 2, 0, 1, 0), nul, nul, 4'hF);
    check("d_rd", 64'(rd_map), 64'h0);
    check("d_wb", 64'(wb_map), 64'h0);
    check("d_done", 64'(done_map), 64'h4);
    check("d_busy", 64'(busy_map), 64'h7);

    // vl = 7 clipped to ELEMS.
    reset_dut();
    run_case(16, 32'h1, 32'h0, 32'h0, mk(3, 1, 2, 7, 1, 0), nul, nul, 4'hF);
    check("e_rd", 64'(rd_map), 64'h1E);
    check("e_wb", 64'(wb_map), 64'h3C0);
    check("e_done", 64'(done_map), 64'h200);
    check("e_wb_order", wb_seq, 64'h0123);

    // vm = 0 with mask 0101.
    reset_dut();
    run_case(16, 32'h1, 32'h0, 32'h0, mk(4, 1, 2, 4, 0, 0), nul, nul, 4'b0101);
`ifdef LANE_CTRL_MASK_EN
    check("f_wb", 64'(wb_map), 64'h140);
    check("f_wb_order", wb_seq, 64'h02);
`else
    check("f_wb", 64'(wb_map), 64'h3C0);
    check("f_wb_order", wb_seq, 64'h0123);
`endif
    check("f_done", 64'(done_map), 64'h200);

    // Reset asserted on cycle 5 of the single-instruction case.
    reset_dut();
    run_case(16, 32'h1, 32'h0, 32'h20, mk(3, 1, 2, 4, 1, 0), nul, nul, 4'hF);
    check("g_rd", 64'(rd_map), 64'h1E);
    check("g_wb", 64'(wb_map), 64'h0);
    check("g_done", 64'(done_map), 64'h0);
    check("g_busy", 64'(busy_map), 64'h3F);
    check("g_ready", 64'(ready_map), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
